// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, load/store and memory-port signals of the shared
//          data-memory arbiter into one bus.
// Ports:   slave = arbiter side, master = requesters + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  // Load/store requester
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;
  // Memory port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // Status
  logic                  busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port data memory between
//          instruction fetch and load/store; one access per MEM_LATENCY+1 cycles.
// Latency: gnt 1 cycle after request sampled in IDLE; rvalid/done MEM_LATENCY
//          edges after the grant edge. Backpressure: requesters hold req until gnt;
//          requests seen while busy wait for IDLE.
// Ports:   clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..4");
  end

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_D  = 1'b1;
  localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  store_q, store_d;

  logic                  if_gnt_q, if_gnt_d;
  logic                  d_gnt_q, d_gnt_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;

  logic grant_if, grant_d, done;

  // On contention the requester that did not win last time gets the port.
  assign grant_if = (state_q == IDLE) && bus.if_req && (!bus.d_req || last_owner_q == OWN_D);
  assign grant_d  = (state_q == IDLE) && bus.d_req  && (!bus.if_req || last_owner_q == OWN_IF);
  assign done     = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_D;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_done_q     <= d_done_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    case (state_q)
      IDLE: begin
        if (grant_if || grant_d) begin
          state_d      = ACCESS;
          owner_d      = grant_d;
          last_owner_d = grant_d;
          cnt_d        = '0;
          store_d      = grant_d && bus.d_we;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 2'd1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output logic
  always_comb begin
    if_gnt_d    = grant_if;
    d_gnt_d     = grant_d;
    if_rvalid_d = done && (owner_q == OWN_IF);
    d_done_d    = done && (owner_q == OWN_D);
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Write strobe lasts only the first ACCESS cycle: it is set on the grant edge
    // and every later edge clears it.
    mem_we_d    = grant_d && bus.d_we;
    busy_d      = busy_q;

    if (grant_if) begin
      mem_addr_d  = bus.if_addr;
      mem_wdata_d = '0;
      busy_d      = 1'b1;
    end else if (grant_d) begin
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
      busy_d      = 1'b1;
    end

    if (done) begin
      busy_d = 1'b0;
      if (owner_q == OWN_IF)  if_rdata_d = bus.mem_rdata;
      else if (!store_q)      d_rdata_d  = bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LATENCY=1 and one
// with MEM_LATENCY=3, each on its own bus and reset.
module tb_mem_port_arbiter;

  logic clk;
  logic rst1, rst3;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1)
  );
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected pattern for the contention run (cycle k = k-th edge after release).
  logic [7:0] exp_if_gnt = 8'b0001_0001; // bit k
  logic [7:0] exp_d_gnt  = 8'b0100_0100;
  logic [7:0] exp_busy   = 8'b0101_0101;

  initial begin
    // ---------------- MEM_LATENCY = 1 ----------------
    rst1 = 1'b1; rst3 = 1'b1;
    b1.if_req = 1'b1; b1.if_addr = 32'h0000_0100;
    b1.d_req  = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h0000_0200; b1.d_wdata = 32'h0;
    b1.mem_rdata = 32'hAAAA_0001;
    b3.if_req = 1'b0; b3.if_addr = 32'h0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = 32'h0; b3.d_wdata = 32'h0; b3.mem_rdata = 32'h0;

    // Reset held 2 cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rst_if_gnt", b1.if_gnt, 1'b0);
      chk1("rst_d_gnt",  b1.d_gnt,  1'b0);
      chk1("rst_busy",   b1.busy,   1'b0);
    end
    chk1("rst_mem_we",    b1.mem_we,    1'b0);
    chk1("rst_if_rvalid", b1.if_rvalid, 1'b0);
    chk1("rst_d_done",    b1.d_done,    1'b0);
    chk("rst_mem_addr",   b1.mem_addr,  32'h0);
    chk("rst_mem_wdata",  b1.mem_wdata, 32'h0);
    chk("rst_if_rdata",   b1.if_rdata,  32'h0);
    chk("rst_d_rdata",    b1.d_rdata,   32'h0);

    // Contention from reset release: if, d, if, d
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk1("cont_if_gnt", b1.if_gnt, exp_if_gnt[k]);
      chk1("cont_d_gnt",  b1.d_gnt,  exp_d_gnt[k]);
      chk1("cont_busy",   b1.busy,   exp_busy[k]);
      if (exp_if_gnt[k]) chk("cont_if_addr", b1.mem_addr, 32'h0000_0100);
      if (exp_d_gnt[k])  chk("cont_d_addr",  b1.mem_addr, 32'h0000_0200);
    end
    b1.if_req = 1'b0; b1.d_req = 1'b0;

    // Single fetch
    b1.if_req = 1'b1; b1.if_addr = 32'h0000_0004; b1.mem_rdata = 32'h2008_0005;
    tick();
    chk1("fetch_gnt",     b1.if_gnt,   1'b1);
    chk1("fetch_d_gnt",   b1.d_gnt,    1'b0);
    chk("fetch_mem_addr", b1.mem_addr, 32'h0000_0004);
    chk1("fetch_mem_we",  b1.mem_we,   1'b0);
    chk1("fetch_busy",    b1.busy,     1'b1);
    b1.if_req = 1'b0;
    tick();
    chk1("fetch_gnt_off", b1.if_gnt,    1'b0);
    chk1("fetch_rvalid",  b1.if_rvalid, 1'b1);
    chk("fetch_rdata",    b1.if_rdata,  32'h2008_0005);
    chk1("fetch_busy_off", b1.busy,     1'b0);
    b1.mem_rdata = 32'h1111_1111;
    tick();
    chk1("fetch_rvalid_off", b1.if_rvalid, 1'b0);
    chk("fetch_rdata_hold",  b1.if_rdata,  32'h2008_0005);

    // Load to seed d_rdata
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h0000_0030; b1.mem_rdata = 32'h1234_5678;
    tick();
    chk1("load_gnt", b1.d_gnt, 1'b1);
    b1.d_req = 1'b0;
    tick();
    chk1("load_done", b1.d_done,  1'b1);
    chk("load_rdata", b1.d_rdata, 32'h1234_5678);

    // Store
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h0000_0010;
    b1.d_wdata = 32'hDEAD_BEEF; b1.mem_rdata = 32'hBADB_AD00;
    tick();
    chk1("st_gnt",      b1.d_gnt,     1'b1);
    chk1("st_mem_we",   b1.mem_we,    1'b1);
    chk("st_mem_addr",  b1.mem_addr,  32'h0000_0010);
    chk("st_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.if_req = 1'b1; // raised while busy, dropped before IDLE
    tick();
    chk1("st_mem_we_off", b1.mem_we,  1'b0);
    chk1("st_done",       b1.d_done,  1'b1);
    chk("st_rdata_hold",  b1.d_rdata, 32'h1234_5678);
    chk("st_wdata_hold",  b1.mem_wdata, 32'hDEAD_BEEF);
    chk1("st_no_if_gnt",  b1.if_gnt,  1'b0);
    b1.if_req = 1'b0;
    tick();
    chk1("st_done_off",   b1.d_done,  1'b0);
    chk1("drop_no_gnt",   b1.if_gnt,  1'b0);
    chk1("drop_busy",     b1.busy,    1'b0);

    // ---------------- MEM_LATENCY = 3 ----------------
    rst3 = 1'b0;
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h0000_0020; b3.mem_rdata = 32'hFFFF_0000;
    tick();
    chk1("l3_gnt",      b3.d_gnt,    1'b1);
    chk1("l3_busy0",    b3.busy,     1'b1);
    chk("l3_addr0",     b3.mem_addr, 32'h0000_0020);
    b3.d_req = 1'b0;
    tick();
    chk1("l3_busy1",    b3.busy,     1'b1);
    chk1("l3_done1",    b3.d_done,   1'b0);
    chk("l3_addr1",     b3.mem_addr, 32'h0000_0020);
    tick();
    chk1("l3_busy2",    b3.busy,     1'b1);
    chk1("l3_done2",    b3.d_done,   1'b0);
    chk("l3_addr2",     b3.mem_addr, 32'h0000_0020);
    b3.mem_rdata = 32'h0000_CAFE;
    tick();
    chk1("l3_done3",    b3.d_done,   1'b1);
    chk("l3_rdata",     b3.d_rdata,  32'h0000_CAFE);
    chk1("l3_busy3",    b3.busy,     1'b0);
    b3.mem_rdata = 32'h0000_0055;
    tick();
    chk1("l3_done_off", b3.d_done,   1'b0);

    // Reset in the 2nd ACCESS cycle of a fetch
    b3.if_req = 1'b1; b3.if_addr = 32'h0000_0040;
    tick();
    chk1("rm_gnt", b3.if_gnt, 1'b1);
    b3.if_req = 1'b0;
    tick();
    rst3 = 1'b1;
    b3.if_req = 1'b1; b3.d_req = 1'b1; b3.d_addr = 32'h0000_0050;
    tick();
    chk1("rm_rvalid", b3.if_rvalid, 1'b0);
    chk("rm_if_rdata", b3.if_rdata, 32'h0);
    chk1("rm_mem_we", b3.mem_we,    1'b0);
    chk1("rm_busy",   b3.busy,      1'b0);
    chk("rm_mem_addr", b3.mem_addr, 32'h0);
    chk("rm_d_rdata", b3.d_rdata,   32'h0);
    rst3 = 1'b0;
    tick();
    chk1("rm_if_first", b3.if_gnt,  1'b1);
    chk1("rm_d_wait",   b3.d_gnt,   1'b0);
    chk1("rm_no_rvalid", b3.if_rvalid, 1'b0);
    chk("rm_regrant_addr", b3.mem_addr, 32'h0000_0040);
    b3.if_req = 1'b0; b3.d_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single-port data memory between the instruction-fetch path (PC-addressed reads) and the load/store path (ALU-addressed reads and writes). Each requester uses a req/gnt handshake. The arbiter latches the winning request, drives the memory port for a fixed latency, then returns read data with a one-cycle valid/done pulse. It sits between the PC/fetch logic, the load/store datapath and datamemory.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEM_LATENCY, 1, cycles from memory-port drive to mem_rdata valid; legal range 1..4

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata holds the fetched word
if_rdata  out  DATA_WIDTH  registered fetch data
d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  load/store address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_done  out  1  one-cycle pulse: access complete (loads and stores)
d_rdata  out  DATA_WIDTH  registered load data
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  high while an access is in flight (state ACCESS)

Behaviour:
- All outputs are registered. Reset value of every output is 0. Internal last_owner resets to DATA, so the first contended grant goes to fetch. Latency counter resets to 0. State resets to IDLE.
- FSM states: IDLE and ACCESS.
- IDLE, arbitration on the sampled if_req/d_req:
  - Only one request: grant it.
  - Both requests: grant the one that is not last_owner (round-robin).
  - Neither request: stay in IDLE.
- On the grant edge:
  - State moves to ACCESS.
  - owner and last_owner are set to the winner.
  - The winner's gnt pulses high for exactly the following cycle.
  - mem_addr/mem_wdata are loaded from the winner. A fetch loads mem_wdata with 0.
  - mem_we is loaded with d_we for a data grant, 0 for a fetch.
  - Counter is cleared and busy goes to 1.
- ACCESS:
  - mem_we is high for only the first ACCESS cycle. It is cleared at the next edge.
  - mem_addr and mem_wdata are held for the entire ACCESS period.
  - The counter increments each edge. At the edge where the counter equals MEM_LATENCY-1, mem_rdata is sampled.
- Completion, at that MEM_LATENCY-th edge after the grant edge:
  - Fetch owner: if_rdata <= mem_rdata.
  - Data owner on a load: d_rdata <= mem_rdata.
  - Data owner on a store: d_rdata is unchanged.
  - The owner's if_rvalid or d_done pulses for the next cycle.
  - busy goes to 0 and state returns to IDLE.
- Throughput: one access per MEM_LATENCY+1 cycles. Arbitration happens only in IDLE; there are no back-to-back grants.
- Requests seen in ACCESS are ignored until IDLE. A requester still asserting req in the IDLE cycle after completion is treated as a new request.
- A req dropped before its grant produces no grant and no side effect.
- if_rdata and d_rdata hold their value until the next completion on the same port.
- Reset asserted in any state, including mid-ACCESS:
  - The access aborts at that edge and state goes to IDLE.
  - All outputs go to 0 and no rvalid/done is issued.
  - mem_we is 0 in the cycle after the reset edge.
  - last_owner returns to DATA.
- MEM_LATENCY outside 1..4 is a configuration error (elaboration-time check). The counter is 2 bits wide.

Test Plan:
- Reset: hold reset 2 cycles with both reqs high -> no gnt; all outputs 0; busy 0; first grant occurs only after reset is released.
- Single fetch, MEM_LATENCY=1: if_req=1, if_addr=0x00000004; memory returns 0x20080005 -> if_gnt high cycle 1 after grant edge; mem_addr=0x4 and mem_we=0; if_rvalid high with if_rdata=0x20080005 the next cycle; busy high exactly 1 cycle.
- Contention: both reqs held high from reset release -> grant order if, d, if, d. No grant within MEM_LATENCY+1 cycles of the previous one. Each gnt matches its own address on mem_addr.
- Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, with prior d_rdata=0x12345678 -> mem_we high exactly 1 cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF; d_done pulses once; d_rdata stays 0x12345678.
- MEM_LATENCY=3 load: d_addr=0x20, mem_rdata=0x0000CAFE valid from the 3rd ACCESS cycle -> d_done and d_rdata=0x0000CAFE appear 3 edges after the grant edge; busy high 3 cycles; mem_addr held 3 cycles.
- Reset mid-operation: MEM_LATENCY=3, reset asserted in the 2nd ACCESS cycle of a fetch -> no if_rvalid; if_rdata=0; mem_we/busy 0 next cycle. With both reqs high afterwards, fetch is granted first.
